peridot_pfc_cmdbridge: RTL and testbench
========================================

# peridot_pfc_cmdbridge

Avalon-MM slave that drives the pin function controller (PFC) command bus from the system interconnect. It issues the 37-bit command word to the top-level bank decoder, pulses the write bit for exactly one cycle, and samples the 32-bit response after a programmable settle time. It is the initiator end of the `pfcif` interface, with the `peridot_pfc` banks as responders. It sits inside the core subsystem on the peripheral clock.

## Interface
Parameters:
- `RESP_WAIT`, default 1: extra cycles between command launch and response sample. Range 0..15.
- `BANK_COUNT`, default 4: number of populated banks. Range 1..4.

Ports:
- `csi_clk`  in  1  sole clock; all logic is on the rising edge.
- `rsi_reset`  in  1  reset, synchronous, active-high.
- `avs_address`  in  4  word address: [3:2] bank, [1:0] register within the bank.
- `avs_read`  in  1  read request.
- `avs_write`  in  1  write request.
- `avs_writedata`  in  32  write data.
- `avs_readdata`  out  32  read data; valid in the cycle `avs_waitrequest`=0 for a read.
- `avs_waitrequest`  out  1  stall; low for exactly one cycle per completed access.
- `coe_pfc_clk`  out  1  equals `csi_clk` (direct assign).
- `coe_pfc_reset`  out  1  `rsi_reset` registered once.
- `coe_pfc_cmd`  out  37  [36] write strobe, [35:34] bank, [33:32] register, [31:0] write data.
- `coe_pfc_resp`  in  32  combinational read data from the selected bank.

## Operation
- The FSM has four states: IDLE, SETUP, WAIT, DONE. WAIT is skipped when `RESP_WAIT`=0.
- **IDLE**
  - `avs_waitrequest`=1, `coe_pfc_cmd[36]`=0.
  - On `avs_read` or `avs_write`: latch address and data into `coe_pfc_cmd[35:0]`, latch the operation, go to SETUP.
  - Read and write asserted together: treated as a read; no write strobe is issued.
- **SETUP** (1 cycle)
  - `coe_pfc_cmd[36]`=1 only if the latched op is write and bank < `BANK_COUNT`.
- **WAIT** (`RESP_WAIT` cycles)
  - Down-counter loaded from `RESP_WAIT`.
  - `coe_pfc_cmd[36]`=0 and `coe_pfc_cmd[35:0]` held.
- **Response capture**
  - `coe_pfc_resp` is registered into `avs_readdata` on the transition into DONE.
  - Out-of-range bank (bank ≥ `BANK_COUNT`): captures 32'h0 instead.
  - Writes do not update `avs_readdata`.
- **DONE** (1 cycle)
  - `avs_waitrequest`=0, then return to IDLE.
  - A request present in the IDLE cycle after DONE is a new access.
- `coe_pfc_cmd[35:0]` holds its last value while idle.
- `avs_readdata` holds until the next read completes.
- `coe_pfc_reset` is 1 while `rsi_reset` is 1, plus one cycle after its release.

## Timing
- **Reset values:**
  - FSM: IDLE.
  - `avs_waitrequest`=1, `avs_readdata`=0.
  - `coe_pfc_cmd`=0, `coe_pfc_reset`=1, WAIT counter=0.
- **Latency:** request sampled in IDLE at cycle T.
  - SETUP at T+1.
  - WAIT at T+2..T+1+`RESP_WAIT`.
  - DONE at T+2+`RESP_WAIT`. Default: DONE at T+3.
- **Throughput:** one access per 3+`RESP_WAIT` cycles for back-to-back requests.
- **Write strobe:** `coe_pfc_cmd[36]` is high exactly one cycle per write. It is never high outside SETUP.
- **Response sample point:** `coe_pfc_resp` is sampled at the end of the last WAIT cycle, or the end of SETUP when `RESP_WAIT`=0. Bank/register are stable at least `RESP_WAIT`+1 cycles before sampling.
- **Reset mid-access:** from any state, the next edge forces the reset values.
  - A pending strobe is dropped.
  - `avs_waitrequest` stays 1; the interrupted access never completes.
- Master changing the address or data while stalled has no effect; the latched values are used.

## Test plan
- **Reset:** hold `rsi_reset` 3 cycles.
  - All outputs at reset values.
  - `coe_pfc_reset` falls one cycle after `rsi_reset` falls.
- **Write, default parameters:** write addr 4'b0110, data 32'hA5A5_0F0F at T.
  - T+1: `coe_pfc_cmd`=37'h1_6A5A_50F0F... i.e. {1,2'd1,2'd2,32'hA5A50F0F}, strobe high for exactly one cycle.
  - `avs_waitrequest`=0 only at T+3.
- **Read, `RESP_WAIT`=3:** read addr 4'b1101, `coe_pfc_resp` driven to 32'hDEAD_BEEF from T+2.
  - `avs_readdata`=32'hDEADBEEF with `avs_waitrequest`=0 at T+5.
  - Strobe never asserted.
- **`BANK_COUNT`=3, bank 3 accesses:**
  - Write: no strobe, completes at T+3.
  - Read: returns 32'h0 even with `coe_pfc_resp`=32'hFFFFFFFF.
- **Simultaneous read and write:** read path taken, no strobe, readdata = `coe_pfc_resp`.
- **Reset during WAIT (`RESP_WAIT`=4):** assert reset at T+3.
  - `avs_waitrequest` stays 1, `coe_pfc_cmd`=0 at T+4.
  - A subsequent read completes normally with latency 6.

Source files
------------

// File: rtl/peridot_pfc_cmdbridge_if.sv
// Bus bundle for the PFC command bridge: the Avalon-MM slave side and the pfcif initiator side.
// The "slave" modport is the bridge; the "master" modport is everything driving and observing it.
interface peridot_pfc_cmdbridge_if;
  logic [3:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic        coe_pfc_clk;
  logic        coe_pfc_reset;
  logic [36:0] coe_pfc_cmd;
  logic [31:0] coe_pfc_resp;

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, coe_pfc_resp,
    output avs_readdata, avs_waitrequest, coe_pfc_clk, coe_pfc_reset, coe_pfc_cmd
  );

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, coe_pfc_resp,
    input  avs_readdata, avs_waitrequest, coe_pfc_clk, coe_pfc_reset, coe_pfc_cmd
  );
endinterface

// File: rtl/peridot_pfc_cmdbridge.sv
// Avalon-MM slave that launches one PFC command per access, strobes writes for a single
// cycle and samples the bank response after a programmable settle time.
module peridot_pfc_cmdbridge #(
  parameter int RESP_WAIT  = 1,
  parameter int BANK_COUNT = 4
) (
  input  logic                         csi_clk,
  input  logic                         rsi_reset,
  peridot_pfc_cmdbridge_if.slave       bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] WAIT_LOAD = 4'((RESP_WAIT > 0) ? (RESP_WAIT - 1) : 0);
  localparam logic [2:0] BANK_LIM  = 3'(BANK_COUNT);

  function automatic logic bank_ok(input logic [1:0] bank);
    return ({1'b0, bank} < BANK_LIM);
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [35:0] cmd_q, cmd_d;
  logic        strobe_q, strobe_d;
  logic        wr_op_q, wr_op_d;
  logic        wait_q, wait_d;
  logic [31:0] rdata_q, rdata_d;
  logic        pfc_rst_q;
  logic        req_wr_s;
  logic        capture_s;

  // Read wins over write when both are requested.
  assign req_wr_s = bus.avs_write & ~bus.avs_read;

  // Next-state, command latch and response capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    strobe_d  = 1'b0;
    wr_op_d   = wr_op_q;
    wait_d    = 1'b1;
    rdata_d   = rdata_q;
    capture_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.avs_read || bus.avs_write) begin
          cmd_d    = {bus.avs_address, bus.avs_writedata};
          wr_op_d  = req_wr_s;
          strobe_d = req_wr_s & bank_ok(bus.avs_address[3:2]);
          state_d  = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        if (RESP_WAIT == 0) begin
          capture_s = 1'b1;
        end else begin
          cnt_d   = WAIT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          capture_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Completion: the response is sampled on the edge that enters DONE.
    if (capture_s) begin
      state_d = S_DONE;
      wait_d  = 1'b0;
      if (!wr_op_q) begin
        rdata_d = bank_ok(cmd_q[35:34]) ? bus.coe_pfc_resp : 32'h0000_0000;
      end else begin
        rdata_d = rdata_q;
      end
    end else begin
      wait_d = 1'b1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge csi_clk) begin
    if (rsi_reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      cmd_q    <= 36'd0;
      strobe_q <= 1'b0;
      wr_op_q  <= 1'b0;
      wait_q   <= 1'b1;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      strobe_q <= strobe_d;
      wr_op_q  <= wr_op_d;
      wait_q   <= wait_d;
      rdata_q  <= rdata_d;
    end
  end

  // Bank reset trails the system reset by one cycle.
  always_ff @(posedge csi_clk) begin
    if (rsi_reset) begin
      pfc_rst_q <= 1'b1;
    end else begin
      pfc_rst_q <= 1'b0;
    end
  end

  assign bus.coe_pfc_clk     = csi_clk;
  assign bus.coe_pfc_reset   = pfc_rst_q;
  assign bus.coe_pfc_cmd     = {strobe_q, cmd_q};
  assign bus.avs_waitrequest = wait_q;
  assign bus.avs_readdata    = rdata_q;

endmodule

// File: tb/tb_peridot_pfc_cmdbridge.sv
// Scoreboard bench for peridot_pfc_cmdbridge across several parameter sets.
module tb_peridot_pfc_cmdbridge;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  typedef struct {
    int          lat;
    logic [31:0] rdata;
    int          strobes;
    logic [36:0] cmd1;
  } exp_t;

  exp_t sb_q[$];

  peridot_pfc_cmdbridge_if if0 ();
  peridot_pfc_cmdbridge_if if1 ();
  peridot_pfc_cmdbridge_if if2 ();
  peridot_pfc_cmdbridge_if if3 ();

  peridot_pfc_cmdbridge #(.RESP_WAIT(1), .BANK_COUNT(4)) u0 (.csi_clk(clk), .rsi_reset(rst), .bus(if0.slave));
  peridot_pfc_cmdbridge #(.RESP_WAIT(3), .BANK_COUNT(4)) u1 (.csi_clk(clk), .rsi_reset(rst), .bus(if1.slave));
  peridot_pfc_cmdbridge #(.RESP_WAIT(1), .BANK_COUNT(3)) u2 (.csi_clk(clk), .rsi_reset(rst), .bus(if2.slave));
  peridot_pfc_cmdbridge #(.RESP_WAIT(4), .BANK_COUNT(4)) u3 (.csi_clk(clk), .rsi_reset(rst), .bus(if3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one access starting just after a falling edge; measures what the DUT does.
  task automatic run_access(virtual peridot_pfc_cmdbridge_if vif,
                            input logic rd, input logic wr,
                            input logic [3:0] addr, input logic [31:0] wdata,
                            input logic [31:0] resp,
                            output int lat, output int strobes,
                            output logic [36:0] cmd1, output logic [36:0] cmd_done,
                            output logic [31:0] rdata, output logic wait_after);
    vif.coe_pfc_resp  = 32'h1234_5678;
    vif.avs_read      = rd;
    vif.avs_write     = wr;
    vif.avs_address   = addr;
    vif.avs_writedata = wdata;
    lat = 0; strobes = 0; cmd1 = 37'd0; cmd_done = 37'd0; rdata = 32'd0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 2) vif.coe_pfc_resp = resp;
      if (vif.coe_pfc_cmd[36]) strobes++;
      if (k == 1) begin
        cmd1 = vif.coe_pfc_cmd;
        vif.avs_address   = ~addr;
        vif.avs_writedata = ~wdata;
      end
      if (vif.avs_waitrequest == 1'b0) begin
        lat = k;
        rdata = vif.avs_readdata;
        cmd_done = vif.coe_pfc_cmd;
        break;
      end
    end
    vif.avs_read  = 1'b0;
    vif.avs_write = 1'b0;
    @(negedge clk);
    wait_after = vif.avs_waitrequest;
    if (vif.coe_pfc_cmd[36]) strobes++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (if0.avs_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_waitreq got %b want 1", if0.avs_waitrequest); end
    checks++;
    if (if0.avs_readdata !== 32'd0) begin errors++; $display("FAIL reset_readdata got %h want 0", if0.avs_readdata); end
    checks++;
    if (if0.coe_pfc_cmd !== 37'd0) begin errors++; $display("FAIL reset_cmd got %h want 0", if0.coe_pfc_cmd); end
    checks++;
    if (if0.coe_pfc_reset !== 1'b1) begin errors++; $display("FAIL reset_pfc_reset got %b want 1", if0.coe_pfc_reset); end
    checks++;
    if (if0.coe_pfc_clk !== clk) begin errors++; $display("FAIL pfc_clk got %b want %b", if0.coe_pfc_clk, clk); end
    rst = 1'b0;
    #1;
    checks++;
    if (if0.coe_pfc_reset !== 1'b1) begin errors++; $display("FAIL pfc_reset_hold got %b want 1", if0.coe_pfc_reset); end
    @(negedge clk);
    checks++;
    if (if0.coe_pfc_reset !== 1'b0) begin errors++; $display("FAIL pfc_reset_release got %b want 0", if0.coe_pfc_reset); end
  endtask

  task automatic test_write_default();
    int lat, st; logic [36:0] c1, cd; logic [31:0] rd; logic wa; exp_t e;
    sb_q.push_back('{lat: 3, rdata: 32'd0, strobes: 1, cmd1: 37'h16_A5A5_0F0F});
    run_access(if0, 1'b0, 1'b1, 4'b0110, 32'hA5A5_0F0F, 32'h0, lat, st, c1, cd, rd, wa);
    e = sb_q.pop_front();
    checks++;
    if (c1 !== e.cmd1) begin errors++; $display("FAIL wr_cmd_t1 got %h want %h", c1, e.cmd1); end
    checks++;
    if (st !== e.strobes) begin errors++; $display("FAIL wr_strobes got %0d want %0d", st, e.strobes); end
    checks++;
    if (lat !== e.lat) begin errors++; $display("FAIL wr_latency got %0d want %0d", lat, e.lat); end
    checks++;
    if (wa !== 1'b1) begin errors++; $display("FAIL wr_waitreq_after got %b want 1", wa); end
    checks++;
    if (cd[35:0] !== e.cmd1[35:0]) begin errors++; $display("FAIL wr_cmd_held got %h want %h", cd[35:0], e.cmd1[35:0]); end
    checks++;
    if (rd !== e.rdata) begin errors++; $display("FAIL wr_readdata got %h want %h", rd, e.rdata); end
  endtask

  task automatic test_read_wait3();
    int lat, st; logic [36:0] c1, cd; logic [31:0] rd; logic wa; exp_t e;
    sb_q.push_back('{lat: 5, rdata: 32'hDEAD_BEEF, strobes: 0, cmd1: {1'b0, 4'b1101, 32'h0000_0011}});
    run_access(if1, 1'b1, 1'b0, 4'b1101, 32'h0000_0011, 32'hDEAD_BEEF, lat, st, c1, cd, rd, wa);
    e = sb_q.pop_front();
    checks++;
    if (lat !== e.lat) begin errors++; $display("FAIL rd3_latency got %0d want %0d", lat, e.lat); end
    checks++;
    if (rd !== e.rdata) begin errors++; $display("FAIL rd3_readdata got %h want %h", rd, e.rdata); end
    checks++;
    if (st !== e.strobes) begin errors++; $display("FAIL rd3_strobes got %0d want %0d", st, e.strobes); end
    checks++;
    if (c1 !== e.cmd1) begin errors++; $display("FAIL rd3_cmd_t1 got %h want %h", c1, e.cmd1); end
  endtask

  task automatic test_bank_range();
    int lat, st; logic [36:0] c1, cd; logic [31:0] rd; logic wa; exp_t e;
    sb_q.push_back('{lat: 3, rdata: 32'd0, strobes: 0, cmd1: {1'b0, 4'b1100, 32'h5555_AAAA}});
    run_access(if2, 1'b0, 1'b1, 4'b1100, 32'h5555_AAAA, 32'h0, lat, st, c1, cd, rd, wa);
    e = sb_q.pop_front();
    checks++;
    if (st !== e.strobes) begin errors++; $display("FAIL b3_wr_strobes got %0d want %0d", st, e.strobes); end
    checks++;
    if (lat !== e.lat) begin errors++; $display("FAIL b3_wr_latency got %0d want %0d", lat, e.lat); end
    checks++;
    if (c1 !== e.cmd1) begin errors++; $display("FAIL b3_wr_cmd got %h want %h", c1, e.cmd1); end
    sb_q.push_back('{lat: 3, rdata: 32'd0, strobes: 0, cmd1: {1'b0, 4'b1110, 32'h0}});
    run_access(if2, 1'b1, 1'b0, 4'b1110, 32'h0, 32'hFFFF_FFFF, lat, st, c1, cd, rd, wa);
    e = sb_q.pop_front();
    checks++;
    if (rd !== e.rdata) begin errors++; $display("FAIL b3_rd_data got %h want %h", rd, e.rdata); end
    checks++;
    if (lat !== e.lat) begin errors++; $display("FAIL b3_rd_latency got %0d want %0d", lat, e.lat); end
    sb_q.push_back('{lat: 3, rdata: 32'd0, strobes: 1, cmd1: {1'b1, 4'b1001, 32'h0BAD_CAFE}});
    run_access(if2, 1'b0, 1'b1, 4'b1001, 32'h0BAD_CAFE, 32'h0, lat, st, c1, cd, rd, wa);
    e = sb_q.pop_front();
    checks++;
    if (st !== e.strobes) begin errors++; $display("FAIL b2_wr_strobes got %0d want %0d", st, e.strobes); end
    checks++;
    if (c1 !== e.cmd1) begin errors++; $display("FAIL b2_wr_cmd got %h want %h", c1, e.cmd1); end
  endtask

  task automatic test_rd_wr_together();
    int lat, st; logic [36:0] c1, cd; logic [31:0] rd; logic wa; exp_t e;
    sb_q.push_back('{lat: 3, rdata: 32'hCAFE_F00D, strobes: 0, cmd1: {1'b0, 4'b1011, 32'h7777_1111}});
    run_access(if0, 1'b1, 1'b1, 4'b1011, 32'h7777_1111, 32'hCAFE_F00D, lat, st, c1, cd, rd, wa);
    e = sb_q.pop_front();
    checks++;
    if (st !== e.strobes) begin errors++; $display("FAIL rw_strobes got %0d want %0d", st, e.strobes); end
    checks++;
    if (rd !== e.rdata) begin errors++; $display("FAIL rw_readdata got %h want %h", rd, e.rdata); end
    checks++;
    if (c1 !== e.cmd1) begin errors++; $display("FAIL rw_cmd got %h want %h", c1, e.cmd1); end
  endtask

  task automatic test_back_to_back();
    int lat, st; logic [36:0] c1, cd; logic [31:0] rd; logic wa; exp_t e;
    sb_q.push_back('{lat: 3, rdata: 32'h1357_9BDF, strobes: 0, cmd1: {1'b0, 4'b0011, 32'h0}});
    sb_q.push_back('{lat: 3, rdata: 32'h1357_9BDF, strobes: 1, cmd1: {1'b1, 4'b0000, 32'hFFFF_0000}});
    run_access(if0, 1'b1, 1'b0, 4'b0011, 32'h0, 32'h1357_9BDF, lat, st, c1, cd, rd, wa);
    e = sb_q.pop_front();
    checks++;
    if (rd !== e.rdata) begin errors++; $display("FAIL b2b_rd_data got %h want %h", rd, e.rdata); end
    run_access(if0, 1'b0, 1'b1, 4'b0000, 32'hFFFF_0000, 32'hAAAA_AAAA, lat, st, c1, cd, rd, wa);
    e = sb_q.pop_front();
    checks++;
    if (rd !== e.rdata) begin errors++; $display("FAIL b2b_wr_keeps_readdata got %h want %h", rd, e.rdata); end
    checks++;
    if (c1 !== e.cmd1) begin errors++; $display("FAIL b2b_wr_cmd got %h want %h", c1, e.cmd1); end
    checks++;
    if (lat !== e.lat) begin errors++; $display("FAIL b2b_wr_latency got %0d want %0d", lat, e.lat); end
  endtask

  task automatic test_reset_mid_wait();
    int lat, st; logic [36:0] c1, cd; logic [31:0] rd; logic wa; exp_t e;
    sb_q.push_back('{lat: 6, rdata: 32'h0BAD_F00D, strobes: 0, cmd1: {1'b0, 4'b0101, 32'h0}});
    run_access(if3, 1'b1, 1'b0, 4'b0101, 32'h0, 32'h0BAD_F00D, lat, st, c1, cd, rd, wa);
    e = sb_q.pop_front();
    checks++;
    if (lat !== e.lat) begin errors++; $display("FAIL w4_latency got %0d want %0d", lat, e.lat); end
    checks++;
    if (rd !== e.rdata) begin errors++; $display("FAIL w4_readdata got %h want %h", rd, e.rdata); end
    // Interrupted write: reset lands on the edge ending T+3.
    if3.avs_write = 1'b1; if3.avs_address = 4'b0001; if3.avs_writedata = 32'h2468_ACE0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (if3.avs_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_mid_waitreq got %b want 1", if3.avs_waitrequest); end
    checks++;
    if (if3.coe_pfc_cmd !== 37'd0) begin errors++; $display("FAIL rst_mid_cmd got %h want 0", if3.coe_pfc_cmd); end
    checks++;
    if (if3.avs_readdata !== 32'd0) begin errors++; $display("FAIL rst_mid_readdata got %h want 0", if3.avs_readdata); end
    rst = 1'b0;
    if3.avs_write = 1'b0;
    @(negedge clk);
    checks++;
    if (if3.avs_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_mid_no_complete got %b want 1", if3.avs_waitrequest); end
    sb_q.push_back('{lat: 6, rdata: 32'h0F0F_1234, strobes: 0, cmd1: {1'b0, 4'b1000, 32'h0}});
    run_access(if3, 1'b1, 1'b0, 4'b1000, 32'h0, 32'h0F0F_1234, lat, st, c1, cd, rd, wa);
    e = sb_q.pop_front();
    checks++;
    if (lat !== e.lat) begin errors++; $display("FAIL post_rst_latency got %0d want %0d", lat, e.lat); end
    checks++;
    if (rd !== e.rdata) begin errors++; $display("FAIL post_rst_readdata got %h want %h", rd, e.rdata); end
    checks++;
    if (st !== e.strobes) begin errors++; $display("FAIL post_rst_strobes got %0d want %0d", st, e.strobes); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    if0.avs_address = 4'd0; if0.avs_read = 1'b0; if0.avs_write = 1'b0; if0.avs_writedata = 32'd0; if0.coe_pfc_resp = 32'd0;
    if1.avs_address = 4'd0; if1.avs_read = 1'b0; if1.avs_write = 1'b0; if1.avs_writedata = 32'd0; if1.coe_pfc_resp = 32'd0;
    if2.avs_address = 4'd0; if2.avs_read = 1'b0; if2.avs_write = 1'b0; if2.avs_writedata = 32'd0; if2.coe_pfc_resp = 32'd0;
    if3.avs_address = 4'd0; if3.avs_read = 1'b0; if3.avs_write = 1'b0; if3.avs_writedata = 32'd0; if3.coe_pfc_resp = 32'd0;
    test_reset();
    test_write_default();
    test_read_wait3();
    test_bank_range();
    test_rd_wr_together();
    test_back_to_back();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
